// File: rtl/rv32_mem_port_arbiter.sv
// rv32_mem_port_arbiter
// Shares one memory port between the multicycle core (port 0) and the
// DMA/debug loader (port 1). Round-robin on ties, one transaction in flight
// at a time, fixed memory read latency, one-cycle ack pulse per completion.
//
//  state   | meaning
//  --------+-------------------------------------------------------------
//  S_IDLE  | no transaction; arbitrate and latch the winner's payload
//  S_ISSUE | memory outputs driven from the latch, write strobe this cycle
//  S_WAIT  | remaining read-latency cycles (never entered when latency 1)
//  S_RESP  | memory data valid; capture rdata/exc and raise ack next cycle

package rv32_mem_port_arbiter_pkg;
   typedef enum logic [1:0] {
      MEM_BYTE = 2'd0,
      MEM_HALF = 2'd1,
      MEM_WORD = 2'd2
   } mem_access_t;

   // bit 0: misaligned, bit 1: access fault, bit 2: bus error, bit 3: reserved
   typedef logic [3:0] mem_exception_mask_t;
endpackage

module rv32_mem_port_arbiter
   import rv32_mem_port_arbiter_pkg::*;
#(
   parameter int unsigned READ_LATENCY  = 1,
   parameter bit          CORE_PRIORITY = 1'b1
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic [1:0]          req_i,
   input  logic [31:0]         addr0_i,
   input  logic [31:0]         addr1_i,
   input  logic [31:0]         wdata0_i,
   input  logic [31:0]         wdata1_i,
   input  logic                wena0_i,
   input  logic                wena1_i,
   input  mem_access_t         access0_i,
   input  mem_access_t         access1_i,
   output logic [1:0]          ack_o,
   output logic [31:0]         rdata_o,
   output mem_exception_mask_t exc_o,
   output logic                busy_o,
   output logic [31:0]         mem_addr_o,
   output logic [31:0]         mem_wr_data_o,
   output logic                mem_wr_ena_o,
   output mem_access_t         mem_access_o,
   input  logic [31:0]         mem_rd_data_i,
   input  mem_exception_mask_t mem_exception_i
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_RESP  = 2'd3
   } state_t;

   // Out-of-range latencies are clamped to the supported 1..3 window.
   localparam int unsigned LAT = (READ_LATENCY < 1) ? 1 :
                                 (READ_LATENCY > 3) ? 3 : READ_LATENCY;
   localparam logic [1:0] WAIT_INIT = (LAT > 1) ? 2'(LAT - 2) : 2'd0;

   state_t              state_q;
   logic [1:0]          wait_cnt_q;
   logic                owner_q;
   logic                last_grant_q;
   logic [1:0]          ack_q;
   logic [31:0]         rdata_q;
   mem_exception_mask_t exc_q;
   logic                busy_q;
   logic [31:0]         mem_addr_q;
   logic [31:0]         mem_wr_data_q;
   logic                mem_wr_ena_q;
   mem_access_t         mem_access_q;

   logic [1:0]          eligible_d;
   logic                grant_d;
   logic [31:0]         sel_addr_d;
   logic [31:0]         sel_wdata_d;
   logic                sel_wena_d;
   mem_access_t         sel_access_d;

   // Arbitration: the ack cycle is already S_IDLE, and the acked requester
   // still shows its old request during it, so that port is masked out.
   always_comb begin
      eligible_d = req_i & ~ack_q;
      grant_d    = 1'b0;
      unique case (eligible_d)
         2'b01:   grant_d = 1'b0;
         2'b10:   grant_d = 1'b1;
         2'b11:   grant_d = ~last_grant_q;
         default: grant_d = 1'b0;
      endcase
   end

   // Payload of the port that would win this cycle.
   always_comb begin
      sel_addr_d   = grant_d ? addr1_i   : addr0_i;
      sel_wdata_d  = grant_d ? wdata1_i  : wdata0_i;
      sel_wena_d   = grant_d ? wena1_i   : wena0_i;
      sel_access_d = grant_d ? access1_i : access0_i;
   end

   // Transaction FSM with all outputs registered.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q       <= S_IDLE;
         wait_cnt_q    <= 2'd0;
         owner_q       <= 1'b0;
         last_grant_q  <= CORE_PRIORITY ? 1'b1 : 1'b0;
         ack_q         <= 2'b00;
         rdata_q       <= 32'd0;
         exc_q         <= '0;
         busy_q        <= 1'b0;
         mem_addr_q    <= 32'd0;
         mem_wr_data_q <= 32'd0;
         mem_wr_ena_q  <= 1'b0;
         mem_access_q  <= MEM_BYTE;
      end else begin
         ack_q        <= 2'b00;
         mem_wr_ena_q <= 1'b0;
         unique case (state_q)
            S_IDLE: begin
               if (|eligible_d) begin
                  // The memory-side registers double as the latched payload.
                  owner_q       <= grant_d;
                  mem_addr_q    <= sel_addr_d;
                  mem_wr_data_q <= sel_wdata_d;
                  mem_access_q  <= sel_access_d;
                  mem_wr_ena_q  <= sel_wena_d;
                  busy_q        <= 1'b1;
                  state_q       <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               if (LAT == 1) begin
                  state_q <= S_RESP;
               end else begin
                  wait_cnt_q <= WAIT_INIT;
                  state_q    <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (wait_cnt_q == 2'd0) begin
                  state_q <= S_RESP;
               end else begin
                  wait_cnt_q <= wait_cnt_q - 2'd1;
               end
            end
            S_RESP: begin
               rdata_q          <= mem_rd_data_i;
               exc_q            <= mem_exception_i;
               ack_q[owner_q]   <= 1'b1;
               last_grant_q     <= owner_q;
               busy_q           <= 1'b0;
               state_q          <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign ack_o         = ack_q;
   assign rdata_o       = rdata_q;
   assign exc_o         = exc_q;
   assign busy_o        = busy_q;
   assign mem_addr_o    = mem_addr_q;
   assign mem_wr_data_o = mem_wr_data_q;
   assign mem_wr_ena_o  = mem_wr_ena_q;
   assign mem_access_o  = mem_access_q;

endmodule

// File: tb/tb_rv32_mem_port_arbiter.sv
// Bench for rv32_mem_port_arbiter: one instance at read latency 1 and one at
// read latency 3, driven by a transaction-level requester/memory model that
// predicts grant order and the exact ack/issue/data cycles.
module tb_rv32_mem_port_arbiter;
   import rv32_mem_port_arbiter_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                rst [2];
   logic [1:0]          req [2];
   logic [31:0]         pa  [2][2];
   logic [31:0]         pw  [2][2];
   logic                pe  [2][2];
   mem_access_t         pc  [2][2];
   logic [1:0]          ack [2];
   logic [31:0]         rdata [2];
   mem_exception_mask_t exc [2];
   logic                busy [2];
   logic [31:0]         maddr [2];
   logic [31:0]         mwdata [2];
   logic                mwe [2];
   mem_access_t         macc [2];
   logic [31:0]         mrd [2];
   mem_exception_mask_t mexc [2];

   int checks   = 0;
   int failures = 0;
   int m_last [2];

   rv32_mem_port_arbiter #(.READ_LATENCY(1), .CORE_PRIORITY(1'b1)) dut_lat1 (
      .clk_i(clk), .rst_i(rst[0]), .req_i(req[0]),
      .addr0_i(pa[0][0]), .addr1_i(pa[0][1]),
      .wdata0_i(pw[0][0]), .wdata1_i(pw[0][1]),
      .wena0_i(pe[0][0]), .wena1_i(pe[0][1]),
      .access0_i(pc[0][0]), .access1_i(pc[0][1]),
      .ack_o(ack[0]), .rdata_o(rdata[0]), .exc_o(exc[0]), .busy_o(busy[0]),
      .mem_addr_o(maddr[0]), .mem_wr_data_o(mwdata[0]), .mem_wr_ena_o(mwe[0]),
      .mem_access_o(macc[0]), .mem_rd_data_i(mrd[0]), .mem_exception_i(mexc[0])
   );

   rv32_mem_port_arbiter #(.READ_LATENCY(3), .CORE_PRIORITY(1'b1)) dut_lat3 (
      .clk_i(clk), .rst_i(rst[1]), .req_i(req[1]),
      .addr0_i(pa[1][0]), .addr1_i(pa[1][1]),
      .wdata0_i(pw[1][0]), .wdata1_i(pw[1][1]),
      .wena0_i(pe[1][0]), .wena1_i(pe[1][1]),
      .access0_i(pc[1][0]), .access1_i(pc[1][1]),
      .ack_o(ack[1]), .rdata_o(rdata[1]), .exc_o(exc[1]), .busy_o(busy[1]),
      .mem_addr_o(maddr[1]), .mem_wr_data_o(mwdata[1]), .mem_wr_ena_o(mwe[1]),
      .mem_access_o(macc[1]), .mem_rd_data_i(mrd[1]), .mem_exception_i(mexc[1])
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Memory contents: a fixed function of the address.
   function automatic logic [31:0] mem_val(input logic [31:0] a);
      if (a == 32'h0000_0010) return 32'hDEAD_BEEF;
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   // Addresses in the 0xEExx_xxxx window fault.
   function automatic mem_exception_mask_t mem_exc(input logic [31:0] a);
      if (a[31:24] == 8'hEE) return a[3:0] | 4'h1;
      return 4'h0;
   endfunction

   task automatic rand_payload(input int d, input int p);
      pa[d][p] = $urandom;
      if ($urandom_range(0, 3) == 0) pa[d][p][31:24] = 8'hEE;
      pw[d][p] = $urandom;
      pe[d][p] = 1'($urandom_range(0, 1));
      pc[d][p] = mem_access_t'($urandom_range(0, 2));
   endtask

   task automatic set_payload(input int d, input int p, input logic [31:0] a,
                              input logic [31:0] w, input logic e, input mem_access_t c);
      pa[d][p] = a;
      pw[d][p] = w;
      pe[d][p] = e;
      pc[d][p] = c;
   endtask

   // Each port in rq issues per_port requests (first one uses the current
   // payload, later ones random). Called and returning on a negedge.
   task automatic run_txns(input int d, input logic [1:0] rq, input int per_port, input string tag);
      int          lat;
      int          cnt [2];
      bit          active;
      int          g;
      int          own;
      logic [31:0] oa;
      logic [31:0] ow;
      logic        oe;
      mem_access_t oc;
      logic [1:0]  exp_ack;
      logic [1:0]  drv;
      logic [1:0]  elig;
      bit          exp_busy;
      lat    = (d == 0) ? 1 : 3;
      cnt[0] = rq[0] ? per_port : 0;
      cnt[1] = rq[1] ? per_port : 0;
      active = 1'b0;
      g      = 0;
      own    = 0;
      oa     = '0;
      ow     = '0;
      oe     = 1'b0;
      oc     = MEM_BYTE;
      for (int s = 0; s < 400 && (active || cnt[0] > 0 || cnt[1] > 0); s++) begin
         exp_ack = 2'b00;
         if (active && s == g + 2 + lat) begin
            exp_ack[own] = 1'b1;
            chk({tag, "_exc"}, 32'(exc[d]), 32'(mem_exc(oa)));
            if (!oe) chk({tag, "_rdata"}, rdata[d], mem_val(oa));
            active    = 1'b0;
            m_last[d] = own;
            cnt[own]--;
            if (cnt[own] > 0) rand_payload(d, own);
         end
         chk({tag, "_ack"}, 32'(ack[d]), 32'(exp_ack));
         exp_busy = active && s >= g + 1 && s <= g + 1 + lat;
         chk({tag, "_busy"}, 32'(busy[d]), 32'(exp_busy));
         chk({tag, "_wr_ena"}, 32'(mwe[d]), 32'(active && s == g + 1 && oe));
         if (active && s == g + 1) begin
            chk({tag, "_addr"}, maddr[d], oa);
            chk({tag, "_access"}, 32'(macc[d]), 32'(oc));
            if (oe) chk({tag, "_wdata"}, mwdata[d], ow);
         end
         if (active && s == g + 1 + lat) begin
            mrd[d]  = mem_val(oa);
            mexc[d] = mem_exc(oa);
         end else begin
            mrd[d]  = $urandom;
            mexc[d] = 4'($urandom);
         end
         drv    = {cnt[1] > 0, cnt[0] > 0};
         req[d] = drv;
         elig   = drv & ~exp_ack;
         if (!active && elig != 2'b00) begin
            if (elig == 2'b01)      own = 0;
            else if (elig == 2'b10) own = 1;
            else                    own = (m_last[d] == 0) ? 1 : 0;
            g      = s;
            active = 1'b1;
            oa     = pa[d][own];
            ow     = pw[d][own];
            oe     = pe[d][own];
            oc     = pc[d][own];
         end
         @(negedge clk);
      end
      req[d] = 2'b00;
      chk({tag, "_timeout"}, 32'(cnt[0] + cnt[1] + int'(active)), 32'd0);
   endtask

   initial begin
      for (int d = 0; d < 2; d++) begin
         rst[d]  = 1'b1;
         req[d]  = 2'b00;
         mrd[d]  = 32'd0;
         mexc[d] = 4'h0;
         m_last[d] = 1;
         for (int p = 0; p < 2; p++) set_payload(d, p, 32'd0, 32'd0, 1'b0, MEM_BYTE);
      end
      repeat (3) @(negedge clk);

      // Reset state of both instances.
      for (int d = 0; d < 2; d++) begin
         chk("rst_ack", 32'(ack[d]), 32'd0);
         chk("rst_busy", 32'(busy[d]), 32'd0);
         chk("rst_wr_ena", 32'(mwe[d]), 32'd0);
         chk("rst_addr", maddr[d], 32'd0);
         chk("rst_wdata", mwdata[d], 32'd0);
         chk("rst_rdata", rdata[d], 32'd0);
         chk("rst_exc", 32'(exc[d]), 32'd0);
         chk("rst_access", 32'(macc[d]), 32'd0);
      end
      rst[0] = 1'b0;
      rst[1] = 1'b0;
      @(negedge clk);

      // Both held right after reset: core first, then strict alternation.
      for (int p = 0; p < 2; p++) rand_payload(0, p);
      run_txns(0, 2'b11, 4, "alternate");

      // Core load of 0x10 returning 0xDEADBEEF.
      set_payload(0, 0, 32'h0000_0010, 32'h0, 1'b0, MEM_WORD);
      run_txns(0, 2'b01, 1, "core_load");

      // Loader store: one write strobe with its address/data.
      set_payload(0, 1, 32'h1000_0004, 32'h1234_5678, 1'b1, MEM_WORD);
      run_txns(0, 2'b10, 1, "dma_store");

      // Faulting core load, then an unaffected loader load.
      set_payload(0, 0, 32'hEE00_0002, 32'h0, 1'b0, MEM_HALF);
      run_txns(0, 2'b01, 1, "core_exc");
      set_payload(0, 1, 32'h0000_0040, 32'h0, 1'b0, MEM_WORD);
      run_txns(0, 2'b10, 1, "after_exc");

      // Latency 3: core load, data only valid in the response cycle.
      set_payload(1, 0, 32'h0000_0100, 32'h0, 1'b0, MEM_WORD);
      run_txns(1, 2'b01, 1, "lat3_load");

      // Reset while a loader load on the latency-3 instance is waiting.
      set_payload(1, 1, 32'h2000_0008, 32'h0, 1'b0, MEM_WORD);
      req[1] = 2'b10;
      @(negedge clk);
      chk("abort_issue_busy", 32'(busy[1]), 32'd1);
      req[1] = 2'b00;
      @(negedge clk);
      chk("abort_wait_busy", 32'(busy[1]), 32'd1);
      rst[1] = 1'b1;
      @(negedge clk);
      rst[1] = 1'b0;
      m_last[1] = 1;
      chk("abort_busy", 32'(busy[1]), 32'd0);
      chk("abort_wr_ena", 32'(mwe[1]), 32'd0);
      for (int i = 0; i < 4; i++) begin
         chk("abort_no_ack", 32'(ack[1]), 32'd0);
         @(negedge clk);
      end
      for (int p = 0; p < 2; p++) rand_payload(1, p);
      run_txns(1, 2'b11, 2, "post_rst");

      // Randomised mixes on both latencies.
      for (int i = 0; i < 8; i++) begin
         for (int d = 0; d < 2; d++) begin
            for (int p = 0; p < 2; p++) rand_payload(d, p);
            run_txns(d, 2'($urandom_range(1, 3)), $urandom_range(1, 4), "random");
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
